// File: rtl/stall_mem.sv
// stall_mem: multi-cycle data-memory responder with a stall/done handshake and a halt-time dump scan.
// Optional macro STALL_MEM_ALIGN_CHECK_EN: unaligned requests complete at once with err and no access.
module stall_mem #(
  parameter int AW      = 8,
  parameter int LATENCY = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          wr,
  input  logic [15:0]   addr,
  input  logic [15:0]   data_in,
  input  logic          createdump,
  output logic [15:0]   data_out,
  output logic          stall,
  output logic          done,
  output logic          err,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [15:0]   dump_data,
  output logic          dump_done
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DUMP} state_t;

  state_t        r_state;
  logic [15:0]   r_mem [2**AW];
  logic          r_wr;
  logic [AW-1:0] r_idx;
  logic [15:0]   r_wdata;
  logic [3:0]    r_cnt;
  logic [AW:0]   r_scan;
  logic [15:0]   r_data_out;
  logic [15:0]   r_dump_data;
  logic [AW-1:0] r_dump_addr;
  logic          r_stall;
  logic          r_done;
  logic          r_err;
  logic          r_dump_valid;
  logic          r_dump_done;

  logic          w_mem_we;
  logic          w_misaligned;
  logic          w_unused;

`ifdef STALL_MEM_ALIGN_CHECK_EN
  assign w_misaligned = addr[0];
`else
  assign w_misaligned = 1'b0;
`endif

  // Upper address bits alias onto the array; bit 0 only matters with the align check.
  assign w_unused = ^{addr[15:AW+1], addr[0]};
  assign w_mem_we = (r_state == S_DONE) && r_wr;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Outputs are registered, so they trail the state by one cycle; commits happen leaving DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_wr         <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_scan       <= '0;
      r_data_out   <= '0;
      r_dump_data  <= '0;
      r_dump_addr  <= '0;
      r_stall      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_stall      <= 1'b0;
          r_done       <= 1'b0;
          r_err        <= 1'b0;
          r_dump_valid <= 1'b0;
          r_dump_done  <= 1'b0;
          if (enable) begin
            r_wr    <= wr;
            r_idx   <= addr[AW:1];
            r_wdata <= data_in;
            r_cnt   <= 4'(LATENCY - 1);
            if (w_misaligned) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else if (LATENCY == 1) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_BUSY;
            end
          end else if (createdump) begin
            r_scan      <= '0;
            r_dump_addr <= '0;
            r_state     <= S_DUMP;
          end
        end
        S_BUSY: begin
          r_stall <= 1'b1;
          r_done  <= 1'b0;
          r_cnt   <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_stall <= 1'b0;
          r_done  <= 1'b1;
          r_err   <= 1'b0;
          if (!r_wr) begin
            r_data_out <= r_mem[r_idx];
          end
          r_state <= S_IDLE;
        end
        S_DUMP: begin
          if (r_scan[AW]) begin
            r_dump_valid <= 1'b0;
            r_dump_done  <= 1'b1;
            r_dump_addr  <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_dump_valid <= 1'b1;
            r_dump_addr  <= r_scan[AW-1:0];
            r_dump_data  <= r_mem[r_scan[AW-1:0]];
            r_scan       <= r_scan + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign stall      = r_stall;
  assign done       = r_done;
  assign err        = r_err;
  assign dump_valid = r_dump_valid;
  assign dump_addr  = r_dump_addr;
  assign dump_data  = r_dump_data;
  assign dump_done  = r_dump_done;

endmodule

// File: tb/tb_stall_mem.sv
// tb_stall_mem: directed stimulus against an edge-schedule model of stall_mem (AW=4, LATENCY=3).
// Build with STALL_MEM_ALIGN_CHECK_EN defined to exercise the align-check expectations.
module tb_stall_mem;
  localparam int AW = 4;
  localparam int L  = 3;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          wr = 1'b0;
  logic          createdump = 1'b0;
  logic [15:0]   addr = 16'h0;
  logic [15:0]   data_in = 16'h0;
  logic [15:0]   data_out;
  logic          stall, done, err, dump_valid, dump_done;
  logic [AW-1:0] dump_addr;
  logic [15:0]   dump_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stall_mem #(.AW(AW), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .createdump(createdump), .data_out(data_out), .stall(stall), .done(done), .err(err),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks which edge accepted the last access / dump and derives outputs from edge distances.
  int          cyc = 0;
  int          acc_n = -1000;
  int          dump_n = -1000;
  int          free_edge = 0;
  logic        acc_wr = 1'b0;
  logic        acc_mis = 1'b0;
  logic [15:0] acc_addr = 16'h0;
  logic [15:0] acc_data = 16'h0;
  logic [15:0] m_mem [NW];
  logic [15:0] m_dout = 16'h0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      acc_n = -1000; dump_n = -1000; free_edge = 0; m_dout = 16'h0;
    end else begin
      cyc++;
      if (acc_n >= 0 && !acc_mis && cyc == acc_n + L) begin
        if (acc_wr) m_mem[acc_addr[AW:1]] = acc_data;
        else        m_dout = m_mem[acc_addr[AW:1]];
      end
      if (cyc >= free_edge) begin
        if (enable) begin
          acc_n = cyc; acc_wr = wr; acc_addr = addr; acc_data = data_in;
`ifdef STALL_MEM_ALIGN_CHECK_EN
          acc_mis = addr[0];
`else
          acc_mis = 1'b0;
`endif
          free_edge = acc_mis ? cyc + 1 : cyc + L + 1;
        end else if (createdump) begin
          dump_n = cyc; free_edge = cyc + NW + 2;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    logic e_stall, e_done, e_err, e_dv, e_dd;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_stall = acc_n >= 0 && !acc_mis && cyc >= acc_n + 1 && cyc <= acc_n + L - 1;
      e_done  = acc_n >= 0 && (acc_mis ? cyc == acc_n : cyc == acc_n + L);
      e_err   = acc_n >= 0 && acc_mis && cyc == acc_n;
      e_dv    = dump_n >= 0 && cyc >= dump_n + 1 && cyc <= dump_n + NW;
      e_dd    = dump_n >= 0 && cyc == dump_n + NW + 1;
      check("cyc_stall", 32'(stall), 32'(e_stall));
      check("cyc_done", 32'(done), 32'(e_done));
      check("cyc_err", 32'(err), 32'(e_err));
      check("cyc_dump_valid", 32'(dump_valid), 32'(e_dv));
      check("cyc_dump_done", 32'(dump_done), 32'(e_dd));
      check("cyc_data_out", 32'(data_out), 32'(m_dout));
      if (e_dv) begin
        check("cyc_dump_addr", 32'(dump_addr), 32'(cyc - dump_n - 1));
        check("cyc_dump_data", 32'(dump_data), 32'(m_mem[cyc - dump_n - 1]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One request; lat = cycles from acceptance edge to the done cycle, -1 if done never came.
  task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d,
                     output int lat, output int nstall, output logic e_seen);
    enable = 1'b1; wr = w; addr = a; data_in = d;
    step();
    enable = 1'b0;
    lat = -1; nstall = 0; e_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall) nstall++;
      if (done) begin
        lat = i; e_seen = err;
        break;
      end
    end
    check("req_done_seen", 32'(lat >= 0), 32'(1));
    $display("req wr=%0d addr=%h data=%h lat=%0d stall_cycles=%0d err=%0d data_out=%h",
             w, a, d, lat, nstall, e_seen, data_out);
    step();
  endtask

  initial begin
    int lat, ns, n, k;
    logic e, got;

    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_dump_valid", 32'(dump_valid), 32'(0));
    check("rst_data_out", 32'(data_out), 32'h0000);
    step();

    req(1'b1, 16'h0010, 16'hBEEF, lat, ns, e);
    check("wr_latency", 32'(lat), 32'(3));
    check("wr_stall_cycles", 32'(ns), 32'(2));
    req(1'b0, 16'h0010, 16'h0000, lat, ns, e);
    check("rd_latency", 32'(lat), 32'(3));
    check("rd_data", 32'(data_out), 32'hBEEF);
    req(1'b1, 16'h0020, 16'h1234, lat, ns, e);
    check("wr_keeps_data_out", 32'(data_out), 32'hBEEF);
    req(1'b0, 16'h0000, 16'h0000, lat, ns, e);
    check("rd_alias_word0", 32'(data_out), 32'h1234);

    // enable held high: one completion every LATENCY+1 cycles
    enable = 1'b1; wr = 1'b0; addr = 16'h0010; n = 0;
    repeat (17) begin
      @(negedge clk);
      if (done) n++;
    end
    enable = 1'b0;
    $display("spacing: %0d done pulses in 17 cycles", n);
    check("spacing_done_count", 32'(n), 32'(4));
    step(); step();
    check("spacing_data_out", 32'(data_out), 32'hBEEF);

    req(1'b0, 16'h0000, 16'h0000, lat, ns, e);
    req(1'b0, 16'h0011, 16'h0000, lat, ns, e);
`ifdef STALL_MEM_ALIGN_CHECK_EN
    check("unaligned_latency", 32'(lat), 32'(0));
    check("unaligned_err", 32'(e), 32'(1));
    check("unaligned_data_out", 32'(data_out), 32'h1234);
`else
    check("unaligned_latency", 32'(lat), 32'(3));
    check("unaligned_err", 32'(e), 32'(0));
    check("unaligned_data_out", 32'(data_out), 32'hBEEF);
`endif

    for (int i = 0; i < NW; i++) begin
      req(1'b1, 16'(i * 2), 16'h0100 + 16'(i), lat, ns, e);
    end
    createdump = 1'b1;
    step();
    createdump = 1'b0;
    k = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dump_valid) begin
        check("dump_addr", 32'(dump_addr), 32'(k));
        check("dump_data", 32'(dump_data), 32'h0100 + 32'(k));
        k++;
      end
      if (dump_done) begin
        got = 1'b1;
        check("dump_done_no_valid", 32'(dump_valid), 32'(0));
        break;
      end
    end
    $display("dump: %0d words, dump_done=%0d", k, got);
    check("dump_word_count", 32'(k), 32'(NW));
    check("dump_done_seen", 32'(got), 32'(1));
    step();

    req(1'b1, 16'h0004, 16'h5555, lat, ns, e);
    enable = 1'b1; wr = 1'b1; addr = 16'h0004; data_in = 16'hAAAA;
    step();
    enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_data_out", 32'(data_out), 32'h0000);
    check("midrst_stall", 32'(stall), 32'(0));
    step();
    rst = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) n++;
    end
    $display("reset mid-write: %0d done pulses afterwards", n);
    check("midrst_no_done", 32'(n), 32'(0));
    step();
    req(1'b0, 16'h0004, 16'h0000, lat, ns, e);
    check("midrst_old_value", 32'(data_out), 32'h5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stall_mem.md
Name: stall_mem

Overview:
- Multi-cycle data-memory responder for the pipelined datapath; it is the memory side of the memory-stage access port.
- Accepts one read or write request at a time over an enable/stall/done handshake. It models a fixed access latency so the pipeline's stall logic can be exercised.
- Also provides a sequential dump scan of the whole array for end-of-program inspection, triggered by halt.

Parameters:
- AW, 8, word-address bits; the array holds 2^AW 16-bit words; byte address bits [AW:1] index it.
- LATENCY, 3, cycles from request acceptance to done; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low: 0 = reset.
- enable  in  1  request valid; sampled only in IDLE.
- wr  in  1  1 = write, 0 = read; captured with the request.
- addr  in  16  byte address; captured with the request.
- data_in  in  16  write data; captured with the request.
- createdump  in  1  level request to start the dump scan.
- data_out  out  16  read data of the last completed read.
- stall  out  1  request in flight; the initiator holds off.
- done  out  1  one-cycle pulse when the access completes.
- err  out  1  valid with done; unaligned access (see Optional Feature).
- dump_valid  out  1  dump_addr/dump_data valid this cycle.
- dump_addr  out  AW  word index being dumped.
- dump_data  out  16  contents at dump_addr.
- dump_done  out  1  one-cycle pulse after the last dump word.

Behaviour:

Reset (rst=0, async):
- State goes to IDLE.
- data_out, dump_addr, dump_data and the latency counter go to 0.
- stall, done, err, dump_valid and dump_done go to 0.
- Array contents are not reset.

States: IDLE, BUSY, DONE, DUMP.

IDLE:
- stall=0, done=0.
- On an edge with enable=1: capture wr, addr and data_in; load counter with LATENCY-1.
  - Next state is BUSY; if LATENCY=1, next state is DONE.
- Else on an edge with createdump=1: dump_addr=0, next state DUMP.
- enable has priority over createdump when both are high.

BUSY:
- stall=1.
- Counter decrements each edge. On the edge where it is 0, the access commits:
  - Write: mem[addr[AW:1]] <= captured data.
  - Read: data_out <= mem[addr[AW:1]].
  - Next state is DONE.
- enable is ignored while in BUSY.

DONE:
- done=1, stall=0, for exactly one cycle.
- Next state is always IDLE; enable in this cycle is ignored.
- Minimum request spacing is LATENCY+1 cycles.

Timing of a request accepted at edge N:
- done is high in the cycle after edge N+LATENCY.
- stall is high for cycles N+1 .. N+LATENCY-1 (none when LATENCY=1).

data_out:
- Holds its value until the next read commits.
- Writes never change it.

DUMP:
- Each cycle: dump_valid=1, dump_data=mem[dump_addr]; dump_addr increments on each edge.
- After the word at index 2^AW-1:
  - dump_addr wraps to 0.
  - dump_done pulses for 1 cycle together with the return to IDLE.
  - dump_valid is 0 in that cycle.
- enable is ignored during DUMP.
- createdump still high on return to IDLE starts a new scan; the initiator deasserts it on dump_done.

Address handling:
- Bits above AW are ignored (aliasing), with no error.

Reset mid-operation:
- An uncommitted write is discarded and memory is untouched.
- A scan in progress is abandoned with no dump_done.

Optional Feature:
- Macro: STALL_MEM_ALIGN_CHECK_EN.
- Defined:
  - An accepted request with addr[0]=1 performs no memory access and does not change data_out.
  - It skips BUSY: the next state is DONE, with done=1 and err=1 for that cycle.
- Not defined:
  - addr[0] is ignored; the access proceeds at word addr[AW:1] with normal latency.
  - err is tied 0.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release with enable=0 → stall=done=err=dump_valid=0, data_out=0x0000.
- Write then read, LATENCY=3: write 0xBEEF to 0x0010 at edge N.
  - Expect stall high for 2 cycles and done in the cycle after edge N+3.
  - Then read 0x0010 → done with data_out=0xBEEF; data_out unchanged by a following write of 0x1234 to 0x0020.
- Request spacing: hold enable=1 continuously → done pulses every 4 cycles (LATENCY+1), each access serviced exactly once.
- Unaligned access: read from 0x0011.
  - Macro defined: done and err high in the cycle after acceptance, data_out unchanged.
  - Macro undefined: normal 3-cycle read of word 8, err=0.
- Dump scan, AW=4: preload words 0..15 with 0x0100+i, pulse createdump for 1 cycle.
  - Expect 16 consecutive dump_valid cycles with dump_addr=i and dump_data=0x0100+i.
  - Then a dump_done pulse and a return to IDLE.
- Reset mid-write: accept a write of 0xAAAA to 0x0004 (old value 0x5555), assert rst in the first BUSY cycle.
  - After release, reading 0x0004 returns 0x5555; no done pulse was produced for the aborted write.
